adc_scheduler: RTL

- Owns the two dual-channel serial ADCs (vcap/icap on B, vout/iout on A) and shares conversions between several requesters: the fire-loop current controller, the charge monitor and the telemetry/status logic.
- Generates the ADC chip-select framing and deserialises all four 12-bit channels.
- Arbitrates one conversion frame at a time and returns the results tagged with the requester id.
- Sits between the launch state machine / PWM loop and the ADC pins, and replaces free-running sampling tied to the fire state.

---
 rtl/adc_sched_pkg.sv | 22 ++
 rtl/adc_scheduler_if.sv | 28 ++
 rtl/adc_sched_arb.sv | 68 ++++++
 rtl/adc_scheduler.sv | 123 ++++++++++++
 4 files changed

// File: rtl/adc_sched_pkg.sv
// adc_sched_pkg: state encoding, channel indices and frame bit-window timing
// shared by the ADC scheduler, its arbiter and its requester interface.
package adc_sched_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } state_e;

    localparam int unsigned N_CH     = 4;
    localparam int unsigned SAMPLE_W = 12;

    localparam int unsigned CH_VCAP = 0;
    localparam int unsigned CH_ICAP = 1;
    localparam int unsigned CH_VOUT = 2;
    localparam int unsigned CH_IOUT = 3;

    localparam logic [4:0] FIRST_BIT_CYC = 5'd2;
    localparam logic [4:0] LAST_BIT_CYC  = 5'd13;
    localparam logic [4:0] VALID_CYC     = 5'd14;

endpackage

// File: rtl/adc_scheduler_if.sv
// adc_scheduler_if: requester-facing bus of adc_scheduler (level requests,
// grant pulses, tagged conversion results, busy).
interface adc_scheduler_if
    import adc_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned TAG_W = 2
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    gnt;
    logic                rsp_valid;
    logic [TAG_W-1:0]    rsp_tag;
    logic [SAMPLE_W-1:0] rsp_vcap;
    logic [SAMPLE_W-1:0] rsp_icap;
    logic [SAMPLE_W-1:0] rsp_vout;
    logic [SAMPLE_W-1:0] rsp_iout;
    logic                busy;

    modport master (
        output req,
        input  gnt, rsp_valid, rsp_tag, rsp_vcap, rsp_icap, rsp_vout, rsp_iout, busy
    );

    modport slave (
        input  req,
        output gnt, rsp_valid, rsp_tag, rsp_vcap, rsp_icap, rsp_vout, rsp_iout, busy
    );
endinterface

// File: rtl/adc_sched_arb.sv
// adc_sched_arb: frame-boundary winner selection. Index 0 always wins; with
// ADC_SCHED_RR_EN defined, indices 1..N_REQ-1 share a round-robin pointer.
module adc_sched_arb #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned TAG_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] eff_req,
    input  logic             advance,
    output logic [TAG_W-1:0] winner
);
    logic             found;
    logic [N_REQ-1:0] req_sh;

`ifdef ADC_SCHED_RR_EN
    logic [TAG_W-1:0] ptr_q, ptr_d;

    // Two passes over 1..N_REQ-1: first from the pointer upward, then the wrap.
    always_comb begin
        winner = '0;
        found  = eff_req[0];
        req_sh = '0;
        for (int unsigned j = 1; j < N_REQ; j++) begin
            req_sh = eff_req >> j;
            if (!found && req_sh[0] && j >= 32'(ptr_q)) begin
                winner = TAG_W'(j);
                found  = 1'b1;
            end
        end
        for (int unsigned j = 1; j < N_REQ; j++) begin
            req_sh = eff_req >> j;
            if (!found && req_sh[0] && j < 32'(ptr_q)) begin
                winner = TAG_W'(j);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && winner != '0)
            ptr_d = (32'(winner) == N_REQ - 1) ? TAG_W'(1) : winner + TAG_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= TAG_W'(1);
        else       ptr_q <= ptr_d;
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, reset, advance};

    always_comb begin
        winner = '0;
        found  = 1'b0;
        req_sh = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            req_sh = eff_req >> j;
            if (!found && req_sh[0]) begin
                winner = TAG_W'(j);
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/adc_scheduler.sv
// adc_scheduler: shares the two dual-channel serial ADCs between requesters,
// frames ad_cs, deserialises four 12-bit lanes. Optional macro: ADC_SCHED_RR_EN.
module adc_scheduler
    import adc_sched_pkg::*;
#(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned TAG_W      = 2,
    parameter int unsigned ADC_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  loop_mode,
    adc_scheduler_if.slave        bus,
    output logic                  ad_cs,
    input  logic [1:0]            ad_sdata_a,
    input  logic [1:0]            ad_sdata_b
);
    localparam logic [4:0] LAST_CYC = 5'(ADC_CYCLES - 1);

    state_e                          state_q, state_d;
    logic [4:0]                      f_q, f_d;
    logic [TAG_W-1:0]                tag_q, tag_d;
    logic [TAG_W-1:0]                rsp_tag_q, rsp_tag_d;
    logic [N_REQ-1:0]                gnt_q, gnt_d;
    logic                            cs_q, cs_d;
    logic                            valid_q, valid_d;
    logic [N_CH-1:0][SAMPLE_W-1:0]   sh_q, sh_d;
    logic [N_CH-1:0][SAMPLE_W-1:0]   hold_q, hold_d;
    logic [N_REQ-1:0]                eff_req;
    logic [TAG_W-1:0]                winner;
    logic                            start;

    assign eff_req = bus.req | N_REQ'(loop_mode);
    assign start   = enable && (|eff_req) &&
                     (state_q == S_IDLE || (state_q == S_FRAME && f_q == LAST_CYC));

    adc_sched_arb #(
        .N_REQ (N_REQ),
        .TAG_W (TAG_W)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .eff_req (eff_req),
        .advance (start),
        .winner  (winner)
    );

    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        tag_d     = tag_q;
        rsp_tag_d = rsp_tag_q;
        gnt_d     = '0;
        cs_d      = 1'b0;
        valid_d   = 1'b0;
        sh_d      = sh_q;
        hold_d    = hold_q;

        if (state_q == S_FRAME) begin
            f_d = f_q + 5'd1;
            if (f_q >= FIRST_BIT_CYC && f_q <= LAST_BIT_CYC) begin
                sh_d[CH_VCAP] = {sh_q[CH_VCAP][SAMPLE_W-2:0], ad_sdata_b[1]};
                sh_d[CH_ICAP] = {sh_q[CH_ICAP][SAMPLE_W-2:0], ad_sdata_b[0]};
                sh_d[CH_VOUT] = {sh_q[CH_VOUT][SAMPLE_W-2:0], ad_sdata_a[1]};
                sh_d[CH_IOUT] = {sh_q[CH_IOUT][SAMPLE_W-2:0], ad_sdata_a[0]};
            end
            // Hold loads from the post-shift value so results are visible with rsp_valid.
            if (f_q == VALID_CYC - 5'd1) begin
                hold_d    = sh_d;
                valid_d   = 1'b1;
                rsp_tag_d = tag_q;
            end
            if (f_q == LAST_CYC) begin
                f_d = '0;
                if (!start) state_d = S_IDLE;
            end
        end

        if (start) begin
            state_d = S_FRAME;
            f_d     = '0;
            tag_d   = winner;
            gnt_d   = N_REQ'(1) << winner;
            cs_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            f_q       <= '0;
            tag_q     <= '0;
            rsp_tag_q <= '0;
            gnt_q     <= '0;
            cs_q      <= 1'b0;
            valid_q   <= 1'b0;
            sh_q      <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            f_q       <= f_d;
            tag_q     <= tag_d;
            rsp_tag_q <= rsp_tag_d;
            gnt_q     <= gnt_d;
            cs_q      <= cs_d;
            valid_q   <= valid_d;
            sh_q      <= sh_d;
            hold_q    <= hold_d;
        end
    end

    assign ad_cs         = cs_q;
    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_vcap  = hold_q[CH_VCAP];
    assign bus.rsp_icap  = hold_q[CH_ICAP];
    assign bus.rsp_vout  = hold_q[CH_VOUT];
    assign bus.rsp_iout  = hold_q[CH_IOUT];
    assign bus.busy      = (state_q == S_FRAME);

endmodule
